// File: rtl/raster_cmd_sched_pkg.sv
// Shared types for the rasterizer command scheduler: vertex/colour formats,
// command opcodes, render state and the buffered command record.
package raster_cmd_sched_pkg;

  // Texture address width shared with rasterizer_top.
  localparam int unsigned SCHED_TEX_ADDR_BITS = 12;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef struct packed {
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic        [15:0] z;
    rgb565_t            color;
  } vertex_t;

  typedef enum logic [1:0] {
    OP_DRAW      = 2'd0,
    OP_SET_STATE = 2'd1,
    OP_TEX_WRITE = 2'd2,
    OP_FENCE     = 2'd3
  } sched_op_t;

  typedef struct packed {
    logic filter_bilinear;
    logic modulate_enable;
    logic tex_enable;
  } render_state_t;

  typedef struct packed {
    sched_op_t                      op;
    vertex_t                        v0;
    vertex_t                        v1;
    vertex_t                        v2;
    render_state_t                  state;
    logic [SCHED_TEX_ADDR_BITS-1:0] tex_addr;
    rgb565_t                        tex_data;
  } sched_cmd_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_APPLY
  } sched_state_t;

endpackage

// File: rtl/raster_cmd_sched_if.sv
// Command channel into the scheduler: the producer drives through master,
// the scheduler receives through slave.
interface raster_cmd_sched_if #(
  parameter int unsigned TEX_ADDR_BITS = 12
);
  import raster_cmd_sched_pkg::*;

  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [1:0]               cmd_op;
  vertex_t                  cmd_v0;
  vertex_t                  cmd_v1;
  vertex_t                  cmd_v2;
  logic [2:0]               cmd_state;
  logic [TEX_ADDR_BITS-1:0] cmd_tex_addr;
  rgb565_t                  cmd_tex_data;

  modport master (
    output cmd_valid, cmd_op, cmd_v0, cmd_v1, cmd_v2, cmd_state, cmd_tex_addr, cmd_tex_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_v0, cmd_v1, cmd_v2, cmd_state, cmd_tex_addr, cmd_tex_data,
    output cmd_ready
  );
endinterface

// File: rtl/raster_cmd_sched_fifo.sv
// Command FIFO for raster_cmd_sched: power-of-two depth with a registered
// count and registered full/empty flags.
module raster_cmd_sched_fifo
  import raster_cmd_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic       pop_i,
  input  sched_cmd_t wdata_i,
  output sched_cmd_t rdata_o,
  output logic       full_o,
  output logic       empty_o
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  sched_cmd_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, empty_q;
  logic             push, pop;

  assign push = push_i && !full_q;
  assign pop  = pop_i && !empty_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // NOTE: storage is not reset; count_q alone says which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // NOTE: non-blocking assignments for all state so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == CNT_FULL);
      empty_q  <= (count_d == '0);
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
endmodule

// File: rtl/raster_cmd_sched.sv
// Command scheduler in front of rasterizer_top: issues triangles and defers state/texture
// updates until the fragment pipeline is drained. Optional counters: RASTER_SCHED_STATS_EN.
module raster_cmd_sched
  import raster_cmd_sched_pkg::*;
#(
  parameter int unsigned CMD_DEPTH     = 4,
  parameter int unsigned PIPE_DEPTH    = 16,
  parameter int unsigned TEX_ADDR_BITS = raster_cmd_sched_pkg::SCHED_TEX_ADDR_BITS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  raster_cmd_sched_if.slave        cmd_if,
  output vertex_t                  v0,
  output vertex_t                  v1,
  output vertex_t                  v2,
  output logic                     tri_valid,
  input  logic                     tri_ready,
  input  logic                     rast_busy,
  input  logic                     frag_valid,
  output logic                     tex_enable,
  output logic                     modulate_enable,
  output logic                     tex_filter_bilinear,
  output logic [TEX_ADDR_BITS-1:0] tex_wr_addr,
  output rgb565_t                  tex_wr_data,
  output logic                     tex_wr_en,
  output logic                     fence_done,
  output logic                     idle
`ifdef RASTER_SCHED_STATS_EN
  ,
  output logic [31:0]              stat_tri_count,
  output logic [31:0]              stat_drain_cycles
`endif
);
  localparam int unsigned QW = $clog2(PIPE_DEPTH + 1);
  localparam logic [QW-1:0] QUIET_MAX = QW'(PIPE_DEPTH);

  sched_state_t  state_q, state_d;
  sched_cmd_t    cmd_q, cmd_d, cmd_in, fifo_head;
  render_state_t rstate_q, rstate_d;
  logic          tri_valid_q, tri_valid_d;
  logic          tex_wr_en_q, tex_wr_en_d;
  logic          fence_done_q, fence_done_d;
  logic [QW-1:0] quiet_q, quiet_d;
  logic          drained_q, drained_d;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty, quiet;

  assign cmd_in = '{
    op:       sched_op_t'(cmd_if.cmd_op),
    v0:       cmd_if.cmd_v0,
    v1:       cmd_if.cmd_v1,
    v2:       cmd_if.cmd_v2,
    state:    render_state_t'(cmd_if.cmd_state),
    tex_addr: SCHED_TEX_ADDR_BITS'(cmd_if.cmd_tex_addr),
    tex_data: cmd_if.cmd_tex_data
  };

  assign cmd_if.cmd_ready = !fifo_full;
  assign fifo_push        = cmd_if.cmd_valid && !fifo_full;

  raster_cmd_sched_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (cmd_in),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Any activity (including our own offered triangle) restarts the quiet window;
  // drained stays high out of reset until the first such activity.
  assign quiet     = !rast_busy && !frag_valid && !tri_valid_q;
  assign quiet_d   = !quiet ? '0 : (quiet_q == QUIET_MAX) ? quiet_q : quiet_q + 1'b1;
  assign drained_d = (quiet_d == QUIET_MAX) || (drained_q && quiet);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    rstate_d     = rstate_q;
    tri_valid_d  = tri_valid_q;
    tex_wr_en_d  = 1'b0;
    fence_done_d = 1'b0;
    fifo_pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cmd_d    = fifo_head;
          if (fifo_head.op == OP_DRAW) begin
            tri_valid_d = 1'b1;
            state_d     = S_ISSUE;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end
      S_ISSUE: begin
        if (tri_ready) begin
          tri_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      // Effects are registered on the way into APPLY so they are visible during it.
      S_DRAIN: begin
        if (drained_q) begin
          state_d = S_APPLY;
          case (cmd_q.op)
            OP_SET_STATE: rstate_d     = cmd_q.state;
            OP_TEX_WRITE: tex_wr_en_d  = 1'b1;
            OP_FENCE:     fence_done_d = 1'b1;
            default:      ;
          endcase
        end
      end
      S_APPLY: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cmd_q        <= '0;
      rstate_q     <= '0;
      tri_valid_q  <= 1'b0;
      tex_wr_en_q  <= 1'b0;
      fence_done_q <= 1'b0;
      quiet_q      <= '0;
      drained_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      rstate_q     <= rstate_d;
      tri_valid_q  <= tri_valid_d;
      tex_wr_en_q  <= tex_wr_en_d;
      fence_done_q <= fence_done_d;
      quiet_q      <= quiet_d;
      drained_q    <= drained_d;
    end
  end

  assign v0                  = cmd_q.v0;
  assign v1                  = cmd_q.v1;
  assign v2                  = cmd_q.v2;
  assign tri_valid           = tri_valid_q;
  assign tex_enable          = rstate_q.tex_enable;
  assign modulate_enable     = rstate_q.modulate_enable;
  assign tex_filter_bilinear = rstate_q.filter_bilinear;
  assign tex_wr_addr         = TEX_ADDR_BITS'(cmd_q.tex_addr);
  assign tex_wr_data         = cmd_q.tex_data;
  assign tex_wr_en           = tex_wr_en_q;
  assign fence_done          = fence_done_q;
  assign idle                = fifo_empty && (state_q == S_IDLE) && drained_q;

`ifdef RASTER_SCHED_STATS_EN
  logic [31:0] stat_tri_q, stat_drain_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_tri_q   <= '0;
      stat_drain_q <= '0;
    end else begin
      if (tri_valid_q && tri_ready) stat_tri_q   <= stat_tri_q + 32'd1;
      if (state_q == S_DRAIN)       stat_drain_q <= stat_drain_q + 32'd1;
    end
  end

  assign stat_tri_count    = stat_tri_q;
  assign stat_drain_cycles = stat_drain_q;
`endif
endmodule

// File: tb/tb_raster_cmd_sched.sv
// Directed self-checking bench for raster_cmd_sched; expected cycle numbers are
// hand-derived relative to the cycle in which a command first sits at the FIFO head.
module tb_raster_cmd_sched;
  import raster_cmd_sched_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n;
  vertex_t              v0, v1, v2;
  logic                 tri_valid, tri_ready, rast_busy, frag_valid;
  logic                 tex_enable, modulate_enable, tex_filter_bilinear;
  logic [11:0]          tex_wr_addr;
  rgb565_t              tex_wr_data;
  logic                 tex_wr_en, fence_done, idle;
`ifdef RASTER_SCHED_STATS_EN
  logic [31:0]          stat_tri_count, stat_drain_cycles;
`endif

  always #5 clk = ~clk;

  raster_cmd_sched_if #(.TEX_ADDR_BITS(12)) cmd_if ();

  raster_cmd_sched #(.CMD_DEPTH(4), .PIPE_DEPTH(16), .TEX_ADDR_BITS(12)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .cmd_if              (cmd_if),
    .v0                  (v0),
    .v1                  (v1),
    .v2                  (v2),
    .tri_valid           (tri_valid),
    .tri_ready           (tri_ready),
    .rast_busy           (rast_busy),
    .frag_valid          (frag_valid),
    .tex_enable          (tex_enable),
    .modulate_enable     (modulate_enable),
    .tex_filter_bilinear (tex_filter_bilinear),
    .tex_wr_addr         (tex_wr_addr),
    .tex_wr_data         (tex_wr_data),
    .tex_wr_en           (tex_wr_en),
    .fence_done          (fence_done),
    .idle                (idle)
`ifdef RASTER_SCHED_STATS_EN
    ,
    .stat_tri_count      (stat_tri_count),
    .stat_drain_cycles   (stat_drain_cycles)
`endif
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Event logs, sampled on the falling edge: cycle index plus payload.
  int          hs_cyc[$];
  vertex_t     hs_v0[$];
  int          tex_cyc[$];
  logic [11:0] tex_addr_log[$];
  rgb565_t     tex_data_log[$];
  int          fence_cyc[$];
  int          rs_cyc[$];
  logic [2:0]  rs_val[$];
  logic [2:0]  rs_prev = 3'b000;

  function automatic logic [2:0] rstate();
    return {tex_filter_bilinear, modulate_enable, tex_enable};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (tri_valid && tri_ready) begin
        hs_cyc.push_back(cyc);
        hs_v0.push_back(v0);
      end
      if (tex_wr_en) begin
        tex_cyc.push_back(cyc);
        tex_addr_log.push_back(tex_wr_addr);
        tex_data_log.push_back(tex_wr_data);
      end
      if (fence_done) fence_cyc.push_back(cyc);
      if (rstate() != rs_prev) begin
        rs_cyc.push_back(cyc);
        rs_val.push_back(rstate());
      end
      rs_prev = rstate();
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    hs_cyc.delete();
    hs_v0.delete();
    tex_cyc.delete();
    tex_addr_log.delete();
    tex_data_log.delete();
    fence_cyc.delete();
    rs_cyc.delete();
    rs_val.delete();
    rs_prev = rstate();
  endtask

  function automatic vertex_t mkv(input int i);
    vertex_t v;
    v.x     = 16'(i * 100);
    v.y     = 16'(i * 7 + 3);
    v.z     = 16'(i);
    v.color = rgb565_t'(16'(i * 2027));
    return v;
  endfunction

  task automatic drive_cmd(input logic [1:0] op, input vertex_t a, input logic [2:0] st,
                           input logic [11:0] addr, input logic [15:0] data);
    cmd_if.cmd_valid    = 1'b1;
    cmd_if.cmd_op       = op;
    cmd_if.cmd_v0       = a;
    cmd_if.cmd_v1       = ~a;
    cmd_if.cmd_v2       = a ^ 64'h5A5A_0F0F_3C3C_9999;
    cmd_if.cmd_state    = st;
    cmd_if.cmd_tex_addr = addr;
    cmd_if.cmd_tex_data = rgb565_t'(data);
  endtask

  // Offer for one edge; after return the command sits in the FIFO.
  task automatic send(input logic [1:0] op, input vertex_t a, input logic [2:0] st,
                      input logic [11:0] addr, input logic [15:0] data);
    drive_cmd(op, a, st, addr, data);
    step();
    cmd_if.cmd_valid = 1'b0;
  endtask

  int t0, last_break, quiet0;

  initial begin
    rst_n      = 1'b0;
    tri_ready  = 1'b0;
    rast_busy  = 1'b0;
    frag_valid = 1'b0;
    drive_cmd(2'd0, '0, 3'b000, 12'h000, 16'h0000);
    cmd_if.cmd_valid = 1'b0;
    repeat (3) step();

    // Reset state.
    check("rst_idle", idle, 1);
    check("rst_cmd_ready", cmd_if.cmd_ready, 1);
    check("rst_tri_valid", tri_valid, 0);
    check("rst_render_state", rstate(), 3'b000);
    check("rst_tex_wr_en", tex_wr_en, 0);
    check("rst_fence_done", fence_done, 0);
    rst_n = 1'b1;
    step();
    check("post_rst_idle", idle, 1);

    // Three back-to-back DRAWs: handshakes at head+1, +3, +5.
    clear_logs();
    tri_ready = 1'b1;
    send(OP_DRAW, mkv(1), 3'b000, 12'h0, 16'h0);
    t0 = cyc;
    send(OP_DRAW, mkv(2), 3'b000, 12'h0, 16'h0);
    send(OP_DRAW, mkv(3), 3'b000, 12'h0, 16'h0);
    repeat (8) step();
    check("draw_hs_count", hs_cyc.size(), 3);
    for (int i = 0; i < hs_cyc.size() && i < 3; i++) begin
      check($sformatf("draw_hs_cycle%0d", i), hs_cyc[i], t0 + 1 + 2 * i);
      check($sformatf("draw_hs_v0_%0d", i), hs_v0[i], mkv(i + 1));
    end
    check("draw_state_unchanged", rs_cyc.size(), 0);

    // DRAW + SET_STATE 101 behind 20 busy cycles and a burst of fragments.
    // Quiet cycles L+1..L+16 fill the counter, so the state lands in cycle L+18.
    clear_logs();
    rast_busy = 1'b1;
    send(OP_DRAW, mkv(4), 3'b000, 12'h0, 16'h0);
    send(OP_SET_STATE, mkv(0), 3'b101, 12'h0, 16'h0);
    repeat (18) step();
    rast_busy  = 1'b0;
    last_break = 0;
    for (int i = 0; i < 10; i++) begin
      frag_valid = (i % 2 == 0);
      if (frag_valid) last_break = cyc;
      step();
    end
    frag_valid = 1'b0;
    repeat (25) step();
    check("state_draw_hs", hs_cyc.size(), 1);
    check("state_change_count", rs_cyc.size(), 1);
    if (rs_cyc.size() > 0) begin
      check("state_change_cycle", rs_cyc[0], last_break + 18);
      check("state_change_value", rs_val[0], 3'b101);
    end
    check("state_filter", tex_filter_bilinear, 1);
    check("state_modulate", modulate_enable, 0);
    check("state_tex_en", tex_enable, 1);

    // TEX_WRITE held behind a stuck fragment stream; pulse 17 cycles after release.
    clear_logs();
    frag_valid = 1'b1;
    send(OP_TEX_WRITE, mkv(0), 3'b000, 12'h2A5, 16'hBEEF);
    repeat (30) step();
    check("stall_no_write", tex_cyc.size(), 0);
    frag_valid = 1'b0;
    quiet0     = cyc;
    repeat (25) step();
    check("stall_write_count", tex_cyc.size(), 1);
    if (tex_cyc.size() > 0) begin
      check("stall_write_cycle", tex_cyc[0], quiet0 + 17);
      check("stall_write_addr", tex_addr_log[0], 12'h2A5);
      check("stall_write_data", tex_data_log[0], 16'hBEEF);
    end

    // Four TEX_WRITEs on a drained pipe: head+2, then every 3 cycles.
    clear_logs();
    send(OP_TEX_WRITE, mkv(0), 3'b000, 12'h000, 16'h0000);
    t0 = cyc;
    send(OP_TEX_WRITE, mkv(0), 3'b000, 12'h001, 16'h1111);
    send(OP_TEX_WRITE, mkv(0), 3'b000, 12'h002, 16'h2222);
    send(OP_TEX_WRITE, mkv(0), 3'b000, 12'h003, 16'h3333);
    repeat (15) step();
    check("burst_write_count", tex_cyc.size(), 4);
    for (int i = 0; i < tex_cyc.size() && i < 4; i++) begin
      check($sformatf("burst_write_cycle%0d", i), tex_cyc[i], t0 + 2 + 3 * i);
      check($sformatf("burst_write_addr%0d", i), tex_addr_log[i], 12'(i));
    end

    // Fill the FIFO behind a stalled triangle, then reset asynchronously mid-ISSUE.
    clear_logs();
    tri_ready = 1'b0;
    send(OP_DRAW, mkv(10), 3'b000, 12'h0, 16'h0);
    repeat (2) step();
    check("full_issue_valid", tri_valid, 1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("full_ready_before%0d", i), cmd_if.cmd_ready, 1);
      send(OP_DRAW, mkv(11 + i), 3'b000, 12'h0, 16'h0);
    end
    drive_cmd(OP_DRAW, mkv(20), 3'b000, 12'h0, 16'h0);
    #1;
    check("full_fifth_refused", cmd_if.cmd_ready, 0);
    step();
    cmd_if.cmd_valid = 1'b0;
    check("full_v0_held", v0, mkv(10));
    #3;
    rst_n = 1'b0;
    #1;
    check("async_tri_valid", tri_valid, 0);
    check("async_cmd_ready", cmd_if.cmd_ready, 1);
    check("async_render_state", rstate(), 3'b000);
    step();
    rst_n = 1'b1;
    clear_logs();
    tri_ready = 1'b1;
    repeat (10) step();
    check("after_rst_no_hs", hs_cyc.size(), 0);
    check("after_rst_idle", idle, 1);

    // FENCE after two DRAWs: fence_done once, 18 cycles after the last handshake.
    clear_logs();
    send(OP_DRAW, mkv(30), 3'b000, 12'h0, 16'h0);
    t0 = cyc;
    send(OP_DRAW, mkv(31), 3'b000, 12'h0, 16'h0);
    send(OP_FENCE, mkv(0), 3'b000, 12'h0, 16'h0);
    repeat (30) step();
    check("fence_hs_count", hs_cyc.size(), 2);
    if (hs_cyc.size() > 1) check("fence_hs2_cycle", hs_cyc[1], t0 + 3);
    check("fence_count", fence_cyc.size(), 1);
    if (fence_cyc.size() > 0) check("fence_cycle", fence_cyc[0], t0 + 21);
    check("fence_end_idle", idle, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
